// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit constants and a counter width helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_W-1:0] ADJ_ADD    = 4'd3;
    localparam logic [BCD_W-1:0] BCD_NINE   = 4'd9;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step over DIGITS BCD digits: every digit >= 5 gets +3,
// then the digit vector shifts left by one taking bit_i into the ones LSB.
// The bit leaving the top digit's MSB is returned as carry_o.
module bcd_dabble_step
    import bin2bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [DIGITS*BCD_W-1:0] digits_i,
    input  logic                    bit_i,
    output logic [DIGITS*BCD_W-1:0] digits_o,
    output logic                    carry_o
);

    logic [DIGITS*BCD_W-1:0] adj;

    // Add-3 correction on each digit before the shift.
    always_comb begin
        adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (digits_i[d*BCD_W +: BCD_W] >= ADJ_THRESH) begin
                adj[d*BCD_W +: BCD_W] = digits_i[d*BCD_W +: BCD_W] + ADJ_ADD;
            end else begin
                adj[d*BCD_W +: BCD_W] = digits_i[d*BCD_W +: BCD_W];
            end
        end
    end

    assign {carry_o, digits_o} = {adj, bit_i};

endmodule

// File: rtl/seq_bin2bcd_multi.sv
// Sequential multi-channel binary-to-BCD converter. One shared dabble engine
// converts CHANNELS captured inputs one after another, BIN_W steps each, and
// writes each channel's digits and overflow flag into its own output slot.
// Optional build macro: BIN2BCD_SAT_EN -- overflowing channels show all nines.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request, in_ready=1
// ST_CONV | engine shifting, one dabble step per clock, busy=1
// ST_DONE | all slots written, out_valid=1 until out_ready
module seq_bin2bcd_multi
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS*BIN_W-1:0]        bin_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*DIGITS*BCD_W-1:0] bcd_out,
    output logic [CHANNELS-1:0]              ovf,
    output logic                             busy
);

    localparam int STEP_W = clog2_min1(BIN_W);
    localparam int CH_W   = clog2_min1(CHANNELS);
    localparam int DIG_W  = DIGITS * BCD_W;
    localparam int CAP_W  = CHANNELS * BIN_W;
    localparam int OUT_W  = CHANNELS * DIG_W;

    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(BIN_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);

    state_e            state_q, state_d;
    logic [CAP_W-1:0]  cap_q, cap_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic              sticky_q, sticky_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [OUT_W-1:0]  bcd_q, bcd_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;

    logic [DIG_W-1:0]  dig_step;
    logic              carry_step;
    logic              sticky_step;
    logic [DIG_W-1:0]  slot_dig;

    bcd_dabble_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .digits_i (dig_q),
        .bit_i    (shift_q[BIN_W-1]),
        .digits_o (dig_step),
        .carry_o  (carry_step)
    );

    // Once any bit falls off the top digit the channel is overflowed for good.
    assign sticky_step = sticky_q | carry_step;

`ifdef BIN2BCD_SAT_EN
    assign slot_dig = sticky_step ? {DIGITS{BCD_NINE}} : dig_step;
`else
    assign slot_dig = dig_step;
`endif

    // Next-state, engine datapath and slot write decisions.
    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        shift_d  = shift_q;
        dig_d    = dig_q;
        sticky_d = sticky_q;
        step_d   = step_q;
        ch_d     = ch_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_CONV;
                    shift_d  = bin_in[BIN_W-1:0];
                    cap_d    = bin_in >> BIN_W;
                    dig_d    = '0;
                    sticky_d = 1'b0;
                    step_d   = STEP_LOAD;
                    ch_d     = '0;
                end
            end
            ST_CONV: begin
                dig_d    = dig_step;
                sticky_d = sticky_step;
                shift_d  = shift_q << 1;
                step_d   = step_q - 1'b1;
                if (step_q == '0) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (CH_W'(c) == ch_q) begin
                            bcd_d[c*DIG_W +: DIG_W] = slot_dig;
                            ovf_d[c]                = sticky_step;
                        end
                    end
                    // Next channel is loaded on the same edge its predecessor retires.
                    shift_d  = cap_q[BIN_W-1:0];
                    cap_d    = cap_q >> BIN_W;
                    dig_d    = '0;
                    sticky_d = 1'b0;
                    step_d   = STEP_LOAD;
                    if (ch_q == CH_LAST) begin
                        state_d = ST_DONE;
                        ch_d    = '0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cap_q    <= '0;
            shift_q  <= '0;
            dig_q    <= '0;
            sticky_q <= 1'b0;
            step_q   <= '0;
            ch_q     <= '0;
            bcd_q    <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            shift_q  <= shift_d;
            dig_q    <= dig_d;
            sticky_q <= sticky_d;
            step_q   <= step_d;
            ch_q     <= ch_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CONV);
    assign out_valid = (state_q == ST_DONE);
    assign bcd_out   = bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_bin2bcd_multi.sv
// Bench for seq_bin2bcd_multi: four parameterisations side by side, a decimal
// model computing expected digits from plain integer arithmetic, and one
// compare process checking every result-valid cycle against that model.
module tb_seq_bin2bcd_multi;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // u0: defaults (8,3,2)
    logic iv0, or0, ir0, ov0, busy0;
    logic [15:0] bin0;
    logic [23:0] bcd0;
    logic [1:0]  ovf0;
    // u1: (8,2,1)
    logic iv1, or1, ir1, ov1, busy1;
    logic [7:0] bin1;
    logic [7:0] bcd1;
    logic [0:0] ovf1;
    // u2: (8,3,1)
    logic iv2, or2, ir2, ov2, busy2;
    logic [7:0]  bin2;
    logic [11:0] bcd2;
    logic [0:0]  ovf2;
    // u3: (12,4,3)
    logic iv3, or3, ir3, ov3, busy3;
    logic [35:0] bin3;
    logic [47:0] bcd3;
    logic [2:0]  ovf3;

    logic [23:0] e0_bcd; logic [1:0] e0_ovf;
    logic [7:0]  e1_bcd; logic [0:0] e1_ovf;
    logic [11:0] e2_bcd; logic [0:0] e2_ovf;
    logic [47:0] e3_bcd; logic [2:0] e3_ovf;

    int n_vec = 0;
    int n_err = 0;
    int done2 = 0;

    seq_bin2bcd_multi #(.BIN_W(8), .DIGITS(3), .CHANNELS(2)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .bin_in(bin0),
        .out_valid(ov0), .out_ready(or0), .bcd_out(bcd0), .ovf(ovf0), .busy(busy0));
    seq_bin2bcd_multi #(.BIN_W(8), .DIGITS(2), .CHANNELS(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .bin_in(bin1),
        .out_valid(ov1), .out_ready(or1), .bcd_out(bcd1), .ovf(ovf1), .busy(busy1));
    seq_bin2bcd_multi #(.BIN_W(8), .DIGITS(3), .CHANNELS(1)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .bin_in(bin2),
        .out_valid(ov2), .out_ready(or2), .bcd_out(bcd2), .ovf(ovf2), .busy(busy2));
    seq_bin2bcd_multi #(.BIN_W(12), .DIGITS(4), .CHANNELS(3)) u3 (
        .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .bin_in(bin3),
        .out_valid(ov3), .out_ready(or3), .bcd_out(bcd3), .ovf(ovf3), .busy(busy3));

    function automatic logic m_ovf(input int v, input int nd);
        int p;
        p = 1;
        for (int d = 0; d < nd; d++) p = p * 10;
        return (v >= p);
    endfunction

    // Decimal digits of v, ones digit lowest; all nines on overflow in the saturating build.
    function automatic logic [15:0] m_dig(input int v, input int nd);
        logic [15:0] r;
        logic        sat;
        int          p;
        r   = '0;
        p   = 1;
        sat = 1'b0;
`ifdef BIN2BCD_SAT_EN
        sat = m_ovf(v, nd);
`endif
        for (int d = 0; d < nd; d++) begin
            r[d*4 +: 4] = sat ? 4'd9 : 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int which, input int budget, output int cnt);
        logic v;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            case (which)
                0:       v = ov0;
                1:       v = ov1;
                2:       v = ov2;
                default: v = ov3;
            endcase
        end while (!v && cnt <= budget);
    endtask

    // Model comparison on every cycle a result is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (ov0) begin
                chk("u0 bcd", 64'(bcd0), 64'(e0_bcd));
                chk("u0 ovf", 64'(ovf0), 64'(e0_ovf));
                chk("u0 ready/busy in done", 64'({ir0, busy0}), 64'd0);
            end
            if (ov1) begin
                chk("u1 bcd", 64'(bcd1), 64'(e1_bcd));
                chk("u1 ovf", 64'(ovf1), 64'(e1_ovf));
            end
            if (ov2) begin
                chk("u2 bcd", 64'(bcd2), 64'(e2_bcd));
                chk("u2 ovf", 64'(ovf2), 64'(e2_ovf));
                done2++;
            end
            if (ov3) begin
                chk("u3 bcd", 64'(bcd3), 64'(e3_bcd));
                chk("u3 ovf", 64'(ovf3), 64'(e3_ovf));
            end
        end
    end

    initial begin
        int cnt;
        int guard;
        reset = 1'b1;
        iv0 = 0; or0 = 0; bin0 = '0;
        iv1 = 0; or1 = 0; bin1 = '0;
        iv2 = 0; or2 = 0; bin2 = '0;
        iv3 = 0; or3 = 0; bin3 = '0;
        e0_bcd = '0; e0_ovf = '0; e1_bcd = '0; e1_ovf = '0;
        e2_bcd = '0; e2_ovf = '0; e3_bcd = '0; e3_ovf = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(ir0), 64'd1);
        chk("reset out_valid", 64'(ov0), 64'd0);
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset bcd", 64'(bcd0), 64'd0);
        chk("reset ovf", 64'(ovf0), 64'd0);
        chk("reset u3 bcd/ovf", 64'({ovf3, bcd3}), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Two-channel default conversion
        bin0 = {8'd255, 8'd59};
        iv0  = 1'b1;
        @(posedge clk);
        #1;
        iv0    = 1'b0;
        e0_bcd = {12'(m_dig(255, 3)), 12'(m_dig(59, 3))};
        e0_ovf = {m_ovf(255, 3), m_ovf(59, 3)};
        chk("u0 busy after accept", 64'(busy0), 64'd1);
        wait_valid(0, 40, cnt);
        chk("u0 latency", 64'(cnt), 64'd16);
        chk("u0 literal 255/059", 64'(bcd0), 64'h255059);
        chk("u0 literal ovf", 64'(ovf0), 64'd0);

        // Backpressure in DONE with a pending request
        bin0 = {8'd7, 8'd100};
        iv0  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp in_ready", 64'(ir0), 64'd0);
            chk("bp out_valid", 64'(ov0), 64'd1);
            chk("bp bcd hold", 64'(bcd0), 64'h255059);
        end
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        chk("bp release idle", 64'({ir0, ov0}), 64'b10);
        @(posedge clk);
        #1;
        iv0    = 1'b0;
        chk("bp accept next edge", 64'(busy0), 64'd1);
        e0_bcd = {12'(m_dig(7, 3)), 12'(m_dig(100, 3))};
        e0_ovf = {m_ovf(7, 3), m_ovf(100, 3)};

        // Asynchronous reset in the middle of a conversion
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid reset in_ready", 64'(ir0), 64'd1);
        chk("mid reset out_valid/busy", 64'({ov0, busy0}), 64'd0);
        chk("mid reset bcd", 64'(bcd0), 64'd0);
        chk("mid reset ovf", 64'(ovf0), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bin0 = {8'd200, 8'd99};
        iv0  = 1'b1;
        @(posedge clk);
        #1;
        iv0    = 1'b0;
        e0_bcd = {12'(m_dig(200, 3)), 12'(m_dig(99, 3))};
        e0_ovf = {m_ovf(200, 3), m_ovf(99, 3)};
        wait_valid(0, 40, cnt);
        chk("u0 post-reset latency", 64'(cnt), 64'd16);
        chk("u0 literal 200/099", 64'(bcd0), 64'h200099);
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;

        // Two-digit channel with overflow
        or1  = 1'b1;
        bin1 = 8'd123;
        iv1  = 1'b1;
        @(posedge clk);
        #1;
        iv1    = 1'b0;
        e1_bcd = 8'(m_dig(123, 2));
        e1_ovf = m_ovf(123, 2);
        wait_valid(1, 20, cnt);
        chk("u1 latency", 64'(cnt), 64'd8);
`ifdef BIN2BCD_SAT_EN
        chk("u1 literal 123 sat", 64'(bcd1), 64'h99);
`else
        chk("u1 literal 123 wrap", 64'(bcd1), 64'h23);
`endif
        chk("u1 literal ovf 123", 64'(ovf1), 64'd1);
        @(posedge clk);
        #1;
        bin1 = 8'd99;
        iv1  = 1'b1;
        @(posedge clk);
        #1;
        iv1    = 1'b0;
        e1_bcd = 8'(m_dig(99, 2));
        e1_ovf = m_ovf(99, 2);
        wait_valid(1, 20, cnt);
        chk("u1 literal 99", 64'(bcd1), 64'h99);
        chk("u1 literal ovf 99", 64'(ovf1), 64'd0);

        // Wide three-channel build
        or3  = 1'b1;
        bin3 = {12'd4095, 12'd0, 12'd1000};
        iv3  = 1'b1;
        @(posedge clk);
        #1;
        iv3    = 1'b0;
        e3_bcd = {m_dig(4095, 4), m_dig(0, 4), m_dig(1000, 4)};
        e3_ovf = {m_ovf(4095, 4), m_ovf(0, 4), m_ovf(1000, 4)};
        wait_valid(3, 60, cnt);
        chk("u3 latency", 64'(cnt), 64'd36);
        chk("u3 literal", 64'(bcd3), 64'h4095_0000_1000);
        chk("u3 literal ovf", 64'(ovf3), 64'd0);

        // Exhaustive single-channel sweep, requests back to back
        or2 = 1'b1;
        for (int v = 0; v < 256; v++) begin
            bin2  = 8'(v);
            iv2   = 1'b1;
            guard = 0;
            while (!ir2 && guard < 40) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (!ir2) begin
                chk("u2 ready timeout", 64'(ir2), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            e2_bcd = 12'(m_dig(v, 3));
            e2_ovf = m_ovf(v, 3);
        end
        iv2 = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        chk("u2 results seen", 64'(done2), 64'd256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
